// File: rtl/game_pkg.sv
// Shared types and constants for the ADC front end and the game logic fed by it.
package game_pkg;
    localparam int ADC_W          = 12;
    localparam int ADC_FRAME_BITS = 17;
    localparam int ADC_NULL_IDX   = 4;

    localparam logic CMD_START = 1'b1;
    localparam logic CMD_SGL   = 1'b1;
    localparam logic CMD_MSBF  = 1'b1;

    typedef logic [ADC_W-1:0] adc_sample_t;

    typedef enum logic [1:0] {FR_IDLE, FR_SETUP, FR_SHIFT, FR_GAP} frame_state_t;
    typedef enum logic [1:0] {PR_IDLE, PR_CH0, PR_CH1, PR_DONE} pair_state_t;

    // DIN value for SCLK period idx: start, single-ended, channel, MSB-first, then zeros.
    function automatic logic cmd_bit(input logic ch, input logic [4:0] idx);
        case (idx)
            5'd0:    cmd_bit = CMD_START;
            5'd1:    cmd_bit = CMD_SGL;
            5'd2:    cmd_bit = ch;
            5'd3:    cmd_bit = CMD_MSBF;
            default: cmd_bit = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/adc_spi_frame.sv
// One MCP3202-style conversion frame: cs_n setup, 17 SCLK periods, then cs_n high gap.
module adc_spi_frame
    import game_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int CS_HIGH_CLKS = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_ch,
    input  logic             i_miso,
    output logic             o_done,
    output logic [ADC_W-1:0] o_result,
    output logic             o_sclk,
    output logic             o_cs_n,
    output logic             o_mosi
);
    localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CLKS) ? CLK_DIV : CS_HIGH_CLKS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    frame_state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_bit;
    logic          r_sclk, r_cs_n, r_mosi, r_ch;
    adc_sample_t   r_shift;

    logic w_div_end, w_gap_end, w_last_bit, w_load;
    assign w_div_end  = (r_cnt == CW'(CLK_DIV - 1));
    assign w_gap_end  = (r_cnt == CW'(CS_HIGH_CLKS - 1));
    assign w_last_bit = (r_bit == 5'(ADC_FRAME_BITS - 1));
    assign w_load     = (w_next == FR_SETUP) && (r_state != FR_SETUP);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= FR_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FR_IDLE:  if (i_start) w_next = FR_SETUP;
            FR_SETUP: if (w_div_end) w_next = FR_SHIFT;
            FR_SHIFT: if (w_div_end && r_sclk && w_last_bit) w_next = FR_GAP;
            FR_GAP:   if (w_gap_end) w_next = i_start ? FR_SETUP : FR_IDLE;
            default:  w_next = FR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_ch    <= 1'b0;
            r_shift <= '0;
        end else if (w_load) begin
            // Start bit is presented for the whole setup hold before the first rise.
            r_cnt  <= '0;
            r_bit  <= '0;
            r_cs_n <= 1'b0;
            r_ch   <= i_ch;
            r_mosi <= cmd_bit(i_ch, 5'd0);
        end else begin
            case (r_state)
                FR_SETUP: r_cnt <= w_div_end ? '0 : r_cnt + 1'b1;
                FR_SHIFT: begin
                    if (w_div_end) begin
                        r_cnt <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            if (r_bit >= 5'(ADC_NULL_IDX + 1))
                                r_shift <= {r_shift[ADC_W-2:0], i_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (w_last_bit) begin
                                r_cs_n <= 1'b1;
                                r_mosi <= 1'b0;
                            end else begin
                                r_bit  <= r_bit + 5'd1;
                                r_mosi <= cmd_bit(r_ch, r_bit + 5'd1);
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FR_GAP:  r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign o_done   = (r_state == FR_GAP) && w_gap_end;
    assign o_result = r_shift;
    assign o_sclk   = r_sclk;
    assign o_cs_n   = r_cs_n;
    assign o_mosi   = r_mosi;
endmodule

// File: rtl/dual_adc_sampler.sv
// Periodic CH0/CH1 sampler; publishes both player readings together with a data_valid strobe.
module dual_adc_sampler
    import game_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int CS_HIGH_CLKS  = 8,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             miso,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    output logic [ADC_W-1:0] p1data,
    output logic [ADC_W-1:0] p2data,
    output logic             data_valid,
    output logic             busy
);
    localparam int PW = $clog2(SAMPLE_PERIOD);

    pair_state_t r_state, w_next;
    logic [PW-1:0] r_cnt;
    adc_sample_t   r_shadow, r_p1, r_p2;
    logic          r_dv;
    logic          w_tick, w_start, w_ch, w_done;
    adc_sample_t   w_result;

    assign w_tick = (r_cnt == PW'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_cnt <= '0;
        else                 r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= PR_IDLE;
        else       r_state <= w_next;
    end

    // CH1 is launched on the last gap clock of CH0 so the frames run back-to-back.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_ch    = 1'b0;
        case (r_state)
            PR_IDLE: if (w_tick && enable) begin
                w_next  = PR_CH0;
                w_start = 1'b1;
            end
            PR_CH0: if (w_done) begin
                w_next  = PR_CH1;
                w_start = 1'b1;
                w_ch    = 1'b1;
            end
            PR_CH1:  if (w_done) w_next = PR_DONE;
            PR_DONE: w_next = PR_IDLE;
            default: w_next = PR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_dv     <= 1'b0;
        end else begin
            r_dv <= (r_state == PR_CH1) && w_done;
            if (r_state == PR_CH0 && w_done) r_shadow <= w_result;
            if (r_state == PR_CH1 && w_done) begin
                r_p1 <= r_shadow;
                r_p2 <= w_result;
            end
        end
    end

    adc_spi_frame #(
        .CLK_DIV      (CLK_DIV),
        .CS_HIGH_CLKS (CS_HIGH_CLKS)
    ) u_frame (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (w_start),
        .i_ch     (w_ch),
        .i_miso   (miso),
        .o_done   (w_done),
        .o_result (w_result),
        .o_sclk   (sclk),
        .o_cs_n   (cs_n),
        .o_mosi   (mosi)
    );

    assign p1data     = r_p1;
    assign p2data     = r_p2;
    assign data_valid = r_dv;
    assign busy       = (r_state != PR_IDLE);
endmodule
